// File: rtl/motor_pkg.sv
// Shared types and helpers for the stepper pulse/direction generator.
package motor_pkg;

  localparam int unsigned FREQ_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_TAIL,
    ST_DONE
  } state_e;

  // Highest step rate that still fits a pulse_w-high / pulse_w-low period.
  function automatic int unsigned max_freq(input int unsigned clk_hz, input int unsigned pulse_w);
    return clk_hz / (2 * pulse_w);
  endfunction

endpackage

// File: rtl/step_ramp.sv
// Linear step-rate ramp: tick divider, current frequency and acceleration pulse count.
module step_ramp
  import motor_pkg::*;
#(
  parameter int unsigned FREQ_W    = FREQ_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MIN_FREQ  = 200,
  parameter int unsigned RAMP_STEP = 50,
  parameter int unsigned RAMP_DIV  = 74_250
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic [FREQ_W-1:0] target_i,
  input  logic [CNT_W-1:0]  pulses_left_i,
  output logic [FREQ_W-1:0] cur_freq_o
);

  localparam int unsigned DIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RAMP_DIV - 1);
  localparam logic [FREQ_W-1:0] MIN_F = FREQ_W'(MIN_FREQ);
  localparam logic [FREQ_W:0] STEP_W = (FREQ_W + 1)'(RAMP_STEP);
  localparam logic [FREQ_W:0] DEC_FLOOR = (FREQ_W + 1)'(MIN_FREQ + RAMP_STEP);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [FREQ_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]  accel_q, accel_d;
  logic              tick;
  logic [FREQ_W:0]   cur_wide;
  logic [FREQ_W:0]   up_sum;

  always_comb begin
    div_d    = div_q;
    cur_d    = cur_q;
    accel_d  = accel_q;
    tick     = 1'b0;
    cur_wide = {1'b0, cur_q};
    up_sum   = cur_wide + STEP_W;
    if (init_i) begin
      div_d   = DIV_RELOAD;
      cur_d   = (target_i < MIN_F) ? target_i : MIN_F;
      accel_d = '0;
    end else if (run_i) begin
      tick  = (div_q == '0);
      div_d = tick ? DIV_RELOAD : div_q - 1'b1;
      if (step_i && (cur_q < target_i) && (accel_q != '1)) begin
        accel_d = accel_q + 1'b1;
      end
      // Below the floor the move runs at a constant rate, so no ramp at all.
      if (tick && (target_i >= MIN_F)) begin
        if (pulses_left_i <= accel_q) begin
          cur_d = (cur_wide >= DEC_FLOOR) ? cur_q - STEP_W[FREQ_W-1:0] : MIN_F;
        end else if (cur_q < target_i) begin
          cur_d = (up_sum >= {1'b0, target_i}) ? target_i : up_sum[FREQ_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= DIV_RELOAD;
      cur_q   <= MIN_F;
      accel_q <= '0;
    end else begin
      div_q   <= div_d;
      cur_q   <= cur_d;
      accel_q <= accel_d;
    end
  end

  assign cur_freq_o = cur_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper PUL/DIR generator with linear accel/decel, phase-accumulator rate and pulse shaper.
//   state    | meaning
//   IDLE     | ready for a command
//   SETUP    | DIR settling before the first step edge
//   RUN      | emitting pulses, rate ramped
//   TAIL     | finishing last high phase plus minimum low time
//   DONE     | one-cycle completion strobe
module step_pulse_gen
  import motor_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 74_250_000,
  parameter int unsigned FREQ_W    = FREQ_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned PULSE_W   = 64,
  parameter int unsigned DIR_SETUP = 256,
  parameter int unsigned MIN_FREQ  = 200,
  parameter int unsigned RAMP_STEP = 50,
  parameter int unsigned RAMP_DIV  = 74_250
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_dir_i,
  input  logic [CNT_W-1:0]  cmd_pulses_i,
  input  logic [FREQ_W-1:0] cmd_freq_i,
  input  logic              abort_i,
  output logic              pul_p_o,
  output logic              pul_n_o,
  output logic              dir_p_o,
  output logic              dir_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [CNT_W-1:0]  pulses_left_o
);

  localparam int unsigned PW_W = $clog2(PULSE_W + 2);
  localparam int unsigned SU_W = $clog2(DIR_SETUP + 1);
  localparam logic [PW_W-1:0] PW_C   = PW_W'(PULSE_W);
  localparam logic [PW_W-1:0] PW_SAT = PW_W'(PULSE_W + 1);
  localparam logic [SU_W-1:0] SU_RELOAD = SU_W'(DIR_SETUP - 1);
  localparam logic [32:0] CLK_C = 33'(CLK_HZ);
  localparam logic [FREQ_W-1:0] MAX_FREQ_C = FREQ_W'(max_freq(CLK_HZ, PULSE_W));

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  pl_q, pl_d;
  logic [FREQ_W-1:0] target_q, target_d;
  logic [SU_W-1:0]   su_q, su_d;
  logic [32:0]       acc_q, acc_d;
  logic              pul_q, pul_d;
  logic [PW_W-1:0]   hi_q, hi_d;
  logic [PW_W-1:0]   lo_q, lo_d;
  logic              aborted_q, aborted_d;
  logic              cmd_fire, step_start, ramp_init;
  logic [FREQ_W-1:0] cur_freq;

  assign cmd_fire   = cmd_valid_i && (state_q == ST_IDLE) && !rst_i;
  // Abort has priority over a pulse that would otherwise start this cycle.
  assign step_start = (state_q == ST_RUN) && !abort_i && (acc_q >= CLK_C) &&
                      !pul_q && (lo_q >= PW_C);
  assign ramp_init  = (state_q == ST_SETUP) && !abort_i && (su_q == '0);

  step_ramp #(
    .FREQ_W   (FREQ_W),
    .CNT_W    (CNT_W),
    .MIN_FREQ (MIN_FREQ),
    .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .init_i       (ramp_init),
    .run_i        (state_q == ST_RUN),
    .step_i       (step_start),
    .target_i     (target_q),
    .pulses_left_i(pl_q),
    .cur_freq_o   (cur_freq)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire) state_d = (cmd_pulses_i == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP: if (abort_i) state_d = ST_DONE;
                else if (su_q == '0) state_d = ST_RUN;
      ST_RUN:   if (abort_i || (step_start && (pl_q == CNT_W'(1)))) state_d = ST_TAIL;
      ST_TAIL:  if (!pul_q && (lo_q == PW_SAT)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    pl_d      = pl_q;
    target_d  = target_q;
    su_d      = su_q;
    acc_d     = acc_q;
    aborted_d = aborted_q;
    pul_d     = pul_q;
    hi_d      = hi_q;
    case (state_q)
      ST_IDLE: if (cmd_fire) begin
        dir_d     = cmd_dir_i;
        pl_d      = cmd_pulses_i;
        target_d  = ((cmd_freq_i == '0) || (cmd_freq_i > MAX_FREQ_C)) ? MAX_FREQ_C : cmd_freq_i;
        su_d      = SU_RELOAD;
        aborted_d = 1'b0;
      end
      ST_SETUP: begin
        acc_d = CLK_C;
        if (abort_i) aborted_d = 1'b1;
        else if (su_q != '0) su_d = su_q - 1'b1;
      end
      ST_RUN: begin
        acc_d = acc_q + 33'(cur_freq) - (step_start ? CLK_C : 33'd0);
        if (abort_i) aborted_d = 1'b1;
        if (step_start) pl_d = pl_q - 1'b1;
      end
      default: ;
    endcase
    if (step_start) begin
      pul_d = 1'b1;
      hi_d  = PW_C - 1'b1;
    end else if (pul_q) begin
      if (hi_q == '0) pul_d = 1'b0;
      else            hi_d  = hi_q - 1'b1;
    end
    // Low-time counter saturates one past PULSE_W so TAIL can see a full low phase.
    lo_d = pul_d ? '0 : ((lo_q == PW_SAT) ? lo_q : lo_q + 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q     <= 1'b0;
      pl_q      <= '0;
      target_q  <= '0;
      su_q      <= '0;
      acc_q     <= '0;
      aborted_q <= 1'b0;
      pul_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= PW_SAT;
    end else begin
      dir_q     <= dir_d;
      pl_q      <= pl_d;
      target_q  <= target_d;
      su_q      <= su_d;
      acc_q     <= acc_d;
      aborted_q <= aborted_d;
      pul_q     <= pul_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    cmd_ready_o   = (state_q == ST_IDLE) && !rst_i;
    busy_o        = (state_q != ST_IDLE);
    done_o        = (state_q == ST_DONE);
    aborted_o     = (state_q == ST_DONE) && aborted_q;
    pul_p_o       = pul_q;
    pul_n_o       = ~pul_q;
    dir_p_o       = dir_q;
    dir_n_o       = ~dir_q;
    pulses_left_o = pl_q;
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Stepper-motor pulse/direction generator driving the differential PUL/DIR pairs of the rotation and tilt axis drivers. It accepts a move command (direction, pulse count, target step frequency in Hz) from the motor monitor / frequency-calculation path, ramps the step rate linearly up from a floor frequency, holds, then ramps down so the last pulse is issued at low speed. It reports busy/done and sits in the video clock domain, directly downstream of `frequency_calculation`.

## Interface
Parameters:
- `CLK_HZ`, 74_250_000, frequency of `clk_i` in Hz; phase-accumulator modulus.
- `FREQ_W`, 20, width of frequency values (Hz).
- `CNT_W`, 16, width of pulse counts.
- `PULSE_W`, 64, step high time and minimum low time, in clocks.
- `DIR_SETUP`, 256, clocks between DIR change and first step edge.
- `MIN_FREQ`, 200, ramp floor / start frequency (Hz).
- `RAMP_STEP`, 50, Hz added or removed per ramp tick.
- `RAMP_DIV`, 74_250, clocks per ramp tick.

Ports:
- `clk_i` in 1: single clock (video pixel clock).
- `rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when valid & ready.
- `cmd_dir_i` in 1: direction, 1 = forward.
- `cmd_pulses_i` in CNT_W: pulses to emit.
- `cmd_freq_i` in FREQ_W: target frequency, Hz.
- `abort_i` in 1: stop current move.
- `pul_p_o`, `pul_n_o` out 1: step pair, `pul_n_o` = ~`pul_p_o`.
- `dir_p_o`, `dir_n_o` out 1: direction pair, `dir_n_o` = ~`dir_p_o`.
- `busy_o` out 1: move in progress.
- `done_o` out 1: one-cycle strobe at end of move.
- `aborted_o` out 1: valid with `done_o`; 1 if move ended by abort.
- `pulses_left_o` out CNT_W: remaining pulses.

## Operation
- States: IDLE, SETUP, RUN, TAIL, DONE.
- IDLE: `cmd_ready_o`=1. On accept: latch dir, pulses, target; `dir_p_o` takes `cmd_dir_i` next cycle; → SETUP.
- Target clamp: 0 or > CLK_HZ/(2·PULSE_W) → CLK_HZ/(2·PULSE_W). Target < MIN_FREQ → constant rate at target, no ramp.
- `cmd_pulses_i`=0 → SETUP skipped, DONE next cycle, no pulses, `aborted_o`=0.
- SETUP: count DIR_SETUP clocks, cur_freq ← min(MIN_FREQ, target), acc ← CLK_HZ; → RUN.
- RUN: each clock acc ← acc + cur_freq (33-bit); when acc ≥ CLK_HZ and step output is low for ≥ PULSE_W clocks: acc −= CLK_HZ, start PULSE_W-clock high, pulses_left −1. When pulses_left reaches 0 → TAIL.
- Ramp (every RAMP_DIV clocks in RUN): if pulses_left ≤ accel_pulses → cur_freq ← max(cur_freq − RAMP_STEP, MIN_FREQ); else if cur_freq < target → cur_freq ← min(cur_freq + RAMP_STEP, target). accel_pulses counts pulses emitted while cur_freq < target, saturating at 2^CNT_W−1.
- TAIL: finish high phase plus PULSE_W low clocks; → DONE.
- DONE: `done_o`=1 one cycle; → IDLE.
- Abort: in SETUP → DONE directly (`aborted_o`=1); in RUN → no new pulse, → TAIL, then DONE with `aborted_o`=1; ignored in IDLE/TAIL/DONE. Abort and pulse-start in the same cycle: abort wins, pulse not started.
- `busy_o` = state ≠ IDLE.

## Timing
- Reset values: `pul_p_o`=0, `pul_n_o`=1, `dir_p_o`=0, `dir_n_o`=1, `busy_o`=0, `done_o`=0, `aborted_o`=0, `pulses_left_o`=0, `cmd_ready_o`=0 during reset, 1 the first cycle after.
- Accept at cycle T: `busy_o`=1, `dir_p_o` valid at T+1; first `pul_p_o` rise at T+1+DIR_SETUP+1.
- High time exactly PULSE_W clocks; low time ≥ PULSE_W clocks.
- Last pulse falling edge to `done_o`: PULSE_W+1 clocks.
- Reset mid-move: all outputs to reset values next edge, pulse truncated.
- `pulses_left_o` registered, decrements the cycle the pulse rises.

## Structure
- Package `motor_pkg`: state enum, `MAX_FREQ` derivation function, shared FREQ_W/CNT_W defaults.
- Sub-module `step_ramp`: ramp-tick divider, cur_freq update, accel_pulses counter.
- Top: FSM, phase accumulator, pulse shaper, differential output registers.

## Test plan
(sim params: CLK_HZ=10_000, PULSE_W=4, DIR_SETUP=8, MIN_FREQ=100, RAMP_STEP=100, RAMP_DIV=100)
- Dir=1, 10 pulses, 100 Hz → `dir_p_o`=1 at T+1, first rise T+10, 10 pulses 100 clocks apart, `done_o` at last fall+5, `aborted_o`=0.
- 200 pulses, 1000 Hz → period shrinks from 100 to 10 clocks, symmetric decel, final period 100 clocks, exactly 200 rises.
- 0 pulses → `done_o` one cycle after accept, no pulses, `busy_o` high 1 cycle.
- Freq 5000 (> max 1250) → period clamps to 8 clocks (4 high/4 low).
- Abort after 5th pulse of 50 → high phase completes, 5 pulses total, `done_o` with `aborted_o`=1, `pulses_left_o`=45.
- `rst_i` during a high phase → `pul_p_o`=0, `busy_o`=0 next edge; new command then runs normally.
